// File: rtl/spi_reg_controller.sv
// Turns the SPI slave byte stream into register-bus reads and writes with auto-increment,
// supplies the next MISO byte and counts protocol errors.
module spi_reg_controller #(
   parameter int         ADDR_W      = 4,
   parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              frame_active,
   input  logic              byte_done,
   input  logic [7:0]        rx_byte,
   output logic [7:0]        tx_byte,
   output logic              tx_load,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   output logic              reg_wr,
   output logic              reg_rd,
   input  logic [7:0]        reg_rdata,
   output logic              busy,
   output logic [7:0]        err_count
);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      WRITE,
      FETCH,
      LOAD,
      READ,
      DISCARD
   } state_t;

   state_t            state, state_n;
   logic              frame_q;
   logic              seen_low;
   logic [7:0]        tx_byte_n;
   logic              tx_load_n;
   logic [ADDR_W-1:0] reg_addr_n;
   logic [7:0]        reg_wdata_n;
   logic              reg_wr_n;
   logic [7:0]        err_count_n;
   logic              err_inc;
   logic              frame_start;
   logic [6:0]        rsv_bits;

   // seen_low blocks a frame that was already active when reset released from starting.
   assign frame_start = frame_active && !frame_q && seen_low;
   assign rsv_bits    = rx_byte[6:0] >> ADDR_W;
   assign busy        = (state != IDLE);

   always_comb begin
      state_n     = state;
      tx_byte_n   = tx_byte;
      tx_load_n   = 1'b0;
      reg_addr_n  = reg_addr;
      reg_wdata_n = reg_wdata;
      reg_wr_n    = 1'b0;
      reg_rd      = 1'b0;
      err_inc     = 1'b0;

      if (reg_wr) begin
         reg_addr_n = reg_addr + ADDR_W'(1);
      end

      if (state != IDLE && !frame_active) begin
         state_n   = IDLE;
         tx_byte_n = STATUS_BYTE;
      end else begin
         case (state)
            IDLE: begin
               if (byte_done) begin
                  err_inc = 1'b1;
               end
               if (frame_start) begin
                  state_n   = CMD;
                  tx_byte_n = STATUS_BYTE;
                  tx_load_n = 1'b1;
               end
            end
            CMD: begin
               if (byte_done) begin
                  if (rsv_bits != 7'd0) begin
                     state_n = DISCARD;
                     err_inc = 1'b1;
                  end else begin
                     reg_addr_n = rx_byte[ADDR_W-1:0];
                     state_n    = rx_byte[7] ? FETCH : WRITE;
                  end
               end
            end
            WRITE: begin
               if (byte_done) begin
                  reg_wr_n    = 1'b1;
                  reg_wdata_n = rx_byte;
               end
            end
            FETCH: begin
               reg_rd  = 1'b1;
               state_n = LOAD;
               if (byte_done) begin
                  err_inc = 1'b1;
               end
            end
            LOAD: begin
               tx_byte_n  = reg_rdata;
               tx_load_n  = 1'b1;
               reg_addr_n = reg_addr + ADDR_W'(1);
               state_n    = READ;
               if (byte_done) begin
                  err_inc = 1'b1;
               end
            end
            READ: begin
               // The byte just received was the master clocking out read data; its content is irrelevant.
               if (byte_done) begin
                  state_n = FETCH;
               end
            end
            DISCARD: begin
               state_n = DISCARD;
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end

      err_count_n = (err_inc && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state     <= IDLE;
         frame_q   <= 1'b0;
         seen_low  <= 1'b0;
         tx_byte   <= STATUS_BYTE;
         tx_load   <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= 8'h00;
         reg_wr    <= 1'b0;
         err_count <= 8'h00;
      end else begin
         state     <= state_n;
         frame_q   <= frame_active;
         if (!frame_active) begin
            seen_low <= 1'b1;
         end
         tx_byte   <= tx_byte_n;
         tx_load   <= tx_load_n;
         reg_addr  <= reg_addr_n;
         reg_wdata <= reg_wdata_n;
         reg_wr    <= reg_wr_n;
         err_count <= err_count_n;
      end
   end

endmodule

// File: tb/tb_spi_reg_controller.sv
// Scoreboard bench for spi_reg_controller: stimulus queues expected bus/tx events,
// a monitor pops and compares them whenever the controller strobes.
module tb_spi_reg_controller;

   localparam int KIND_NONE = 0;
   localparam int KIND_WR   = 1;
   localparam int KIND_RD   = 2;
   localparam int KIND_TX   = 3;

   typedef struct {
      int         kind;
      int         cyc;
      logic [7:0] addr;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       n_reset;
   logic       frame_active;
   logic       byte_done;
   logic [7:0] rx_byte;
   logic [7:0] tx_byte;
   logic       tx_load;
   logic [3:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_wr;
   logic       reg_rd;
   logic [7:0] reg_rdata;
   logic       busy;
   logic [7:0] err_count;

   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];

   spi_reg_controller #(.ADDR_W(4), .STATUS_BYTE(8'hA5)) dut (
      .clk          (clk),
      .n_reset      (n_reset),
      .frame_active (frame_active),
      .byte_done    (byte_done),
      .rx_byte      (rx_byte),
      .tx_byte      (tx_byte),
      .tx_load      (tx_load),
      .reg_addr     (reg_addr),
      .reg_wdata    (reg_wdata),
      .reg_wr       (reg_wr),
      .reg_rd       (reg_rd),
      .reg_rdata    (reg_rdata),
      .busy         (busy),
      .err_count    (err_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] rd_model(input logic [3:0] a);
      case (a)
         4'd5:    return 8'h5A;
         4'd6:    return 8'h6B;
         4'd7:    return 8'h7C;
         default: return 8'h00;
      endcase
   endfunction

   // Register file stand-in: read data appears the cycle after the read strobe.
   always @(posedge clk or negedge n_reset) begin
      if (!n_reset) reg_rdata <= 8'h00;
      else if (reg_rd) reg_rdata <= rd_model(reg_addr);
   end

   task automatic check_output(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input int kind, input int at, input logic [7:0] addr, input logic [7:0] data);
      exp_t e;
      e.kind = kind;
      e.cyc  = at;
      e.addr = addr;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic match_event(input int kind, input logic [7:0] addr, input logic [7:0] data);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("[TB] FAIL unexpected_event: got kind %0d addr %0h data %0h, expected none (cycle %0d)",
                  kind, addr, data, cyc);
      end else begin
         e = exp_q.pop_front();
         check_output("event_kind", kind, e.kind);
         check_output("event_cycle", cyc, e.cyc);
         if (kind == KIND_WR || kind == KIND_RD) check_output("event_addr", int'(addr), int'(e.addr));
         if (kind == KIND_WR || kind == KIND_TX) check_output("event_data", int'(data), int'(e.data));
      end
   endtask

   // Monitor: every strobe from the controller must match the head of the queue.
   always @(negedge clk) begin
      if (n_reset) begin
         if (reg_wr || reg_rd) check_output("strobe_exclusive", int'(reg_wr && reg_rd), 0);
         if (reg_wr) match_event(KIND_WR, {4'h0, reg_addr}, reg_wdata);
         if (reg_rd) match_event(KIND_RD, {4'h0, reg_addr}, 8'h00);
         if (tx_load) match_event(KIND_TX, 8'h00, tx_byte);
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic frame_start();
      @(posedge clk);
      #1;
      push_exp(KIND_TX, cyc + 1, 8'h00, 8'hA5);
      frame_active = 1'b1;
      wait_cycles(2);
   endtask

   task automatic frame_end();
      @(posedge clk);
      #1;
      frame_active = 1'b0;
      wait_cycles(3);
   endtask

   task automatic apply_stimulus(input logic [7:0] b, input int kind, input logic [7:0] addr,
                                 input logic [7:0] data);
      @(posedge clk);
      #1;
      if (kind == KIND_WR) push_exp(KIND_WR, cyc + 1, addr, b);
      if (kind == KIND_RD) begin
         push_exp(KIND_RD, cyc + 1, addr, 8'h00);
         push_exp(KIND_TX, cyc + 3, 8'h00, data);
      end
      byte_done = 1'b1;
      rx_byte   = b;
      @(posedge clk);
      #1;
      byte_done = 1'b0;
      wait_cycles(9);
   endtask

   task automatic check_idle(input string name, input int exp_err);
      @(negedge clk);
      check_output({name, "_busy"}, int'(busy), 0);
      check_output({name, "_tx_byte"}, int'(tx_byte), 8'hA5);
      check_output({name, "_err_count"}, int'(err_count), exp_err);
      check_output({name, "_queue_drained"}, exp_q.size(), 0);
   endtask

   initial begin
      n_reset      = 1'b0;
      frame_active = 1'b0;
      byte_done    = 1'b0;
      rx_byte      = 8'h00;
      #12;
      check_output("reset_tx_byte", int'(tx_byte), 8'hA5);
      check_output("reset_tx_load", int'(tx_load), 0);
      check_output("reset_reg_addr", int'(reg_addr), 0);
      check_output("reset_reg_wr", int'(reg_wr), 0);
      check_output("reset_reg_rd", int'(reg_rd), 0);
      check_output("reset_busy", int'(busy), 0);
      check_output("reset_err_count", int'(err_count), 0);
      @(negedge clk);
      n_reset = 1'b1;
      wait_cycles(3);

      $display("[TB] write burst");
      frame_start();
      apply_stimulus(8'h03, KIND_NONE, 8'h00, 8'h00);
      apply_stimulus(8'h11, KIND_WR, 8'h03, 8'h00);
      apply_stimulus(8'h22, KIND_WR, 8'h04, 8'h00);
      frame_end();
      check_idle("write", 0);

      $display("[TB] read burst");
      frame_start();
      apply_stimulus(8'h85, KIND_RD, 8'h05, 8'h5A);
      apply_stimulus(8'h00, KIND_RD, 8'h06, 8'h6B);
      apply_stimulus(8'hFF, KIND_RD, 8'h07, 8'h7C);
      frame_end();
      check_idle("read", 0);

      $display("[TB] address wrap");
      frame_start();
      apply_stimulus(8'h0F, KIND_NONE, 8'h00, 8'h00);
      apply_stimulus(8'hAA, KIND_WR, 8'h0F, 8'h00);
      apply_stimulus(8'hBB, KIND_WR, 8'h00, 8'h00);
      frame_end();
      check_idle("wrap", 0);

      $display("[TB] bad command then valid frame");
      frame_start();
      apply_stimulus(8'h30, KIND_NONE, 8'h00, 8'h00);
      apply_stimulus(8'h77, KIND_NONE, 8'h00, 8'h00);
      frame_end();
      check_idle("bad_cmd", 1);
      frame_start();
      apply_stimulus(8'h02, KIND_NONE, 8'h00, 8'h00);
      apply_stimulus(8'h99, KIND_WR, 8'h02, 8'h00);
      frame_end();
      check_idle("after_bad", 1);

      $display("[TB] abort read after command byte");
      frame_start();
      @(posedge clk);
      #1;
      byte_done = 1'b1;
      rx_byte   = 8'h85;
      @(posedge clk);
      #1;
      byte_done    = 1'b0;
      frame_active = 1'b0;
      wait_cycles(3);
      check_idle("abort", 1);

      $display("[TB] error counter saturation");
      repeat (300) begin
         frame_start();
         apply_stimulus(8'h30, KIND_NONE, 8'h00, 8'h00);
         frame_end();
      end
      check_idle("saturate", 8'hFF);

      $display("[TB] reset in the middle of a write frame");
      frame_start();
      apply_stimulus(8'h08, KIND_NONE, 8'h00, 8'h00);
      apply_stimulus(8'h44, KIND_WR, 8'h08, 8'h00);
      @(negedge clk);
      n_reset = 1'b0;
      #1;
      check_output("midreset_tx_byte", int'(tx_byte), 8'hA5);
      check_output("midreset_err_count", int'(err_count), 0);
      check_output("midreset_reg_addr", int'(reg_addr), 0);
      check_output("midreset_busy", int'(busy), 0);
      check_output("midreset_strobes", int'({tx_load, reg_wr, reg_rd}), 0);
      @(negedge clk);
      n_reset = 1'b1;
      wait_cycles(2);
      apply_stimulus(8'h55, KIND_NONE, 8'h00, 8'h00);
      check_idle("no_resume", 1);
      frame_end();
      frame_start();
      apply_stimulus(8'h09, KIND_NONE, 8'h00, 8'h00);
      apply_stimulus(8'h66, KIND_WR, 8'h09, 8'h00);
      frame_end();
      check_idle("new_frame", 1);

      wait_cycles(5);
      check_output("final_queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
